// File: rtl/data_mem_responder.sv
// Data-memory responder: services one load/store at a time over valid/ready channels,
// with RISC-V sub-word extraction, store byte-enables, configurable latency and fault reporting.
module data_mem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_next;
   logic [3:0]  wait_cnt;
   logic        lat_write;
   logic [2:0]  lat_funct3;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic [31:0] mem [DEPTH_WORDS];

   logic        accept;
   logic        access_en;
   logic        a_write;
   logic [2:0]  a_funct3;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic [31:0] offset;
   logic [1:0]  lane;
   logic [1:0]  size;
   logic [AW-1:0] idx;
   logic        below_base, beyond_end, illegal, misaligned, access_err;
   logic [31:0] rd_word;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_data;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        mem_we;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;

   // With zero latency the access happens on the accept edge, before anything is latched,
   // so the operands come straight from the request port while idle.
   assign access_en = (state == WAIT && wait_cnt == 4'd0) || (LATENCY == 0 && accept);
   assign a_write   = (state == IDLE) ? req_write  : lat_write;
   assign a_funct3  = (state == IDLE) ? req_funct3 : lat_funct3;
   assign a_addr    = (state == IDLE) ? req_addr   : lat_addr;
   assign a_wdata   = (state == IDLE) ? req_wdata  : lat_wdata;

   assign offset     = a_addr - BASE_ADDR;
   assign lane       = offset[1:0];
   assign size       = a_funct3[1:0];
   assign idx        = offset[AW+1:2];
   assign below_base = (a_addr < BASE_ADDR);
   assign beyond_end = (offset[31:2] >= 30'(DEPTH_WORDS));
   assign illegal    = a_write ? (a_funct3 >= 3'd3) : (size == 2'd3 || a_funct3 == 3'd6);
   assign misaligned = (size == 2'd1 && lane[0]) || (size == 2'd2 && lane != 2'd0);
   assign access_err = below_base || beyond_end || illegal || misaligned;

   assign rd_word = mem[idx];
   assign rd_byte = rd_word[8*lane +: 8];
   assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      load_data = 32'd0;
      case (a_funct3)
         3'd0:    load_data = {{24{rd_byte[7]}}, rd_byte};
         3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
         3'd2:    load_data = rd_word;
         3'd4:    load_data = {24'd0, rd_byte};
         3'd5:    load_data = {16'd0, rd_half};
         default: load_data = 32'd0;
      endcase
   end

   always_comb begin
      wr_be   = 4'b0000;
      wr_data = a_wdata;
      case (size)
         2'd0: begin
            wr_be   = 4'b0001 << lane;
            wr_data = {4{a_wdata[7:0]}};
         end
         2'd1: begin
            wr_be   = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{a_wdata[15:0]}};
         end
         2'd2:    wr_be = 4'b1111;
         default: wr_be = 4'b0000;
      endcase
   end

   // Gating with reset_n keeps a held reset from committing a store on a clock edge.
   assign mem_we = access_en && a_write && !access_err && reset_n;

   // NOTE: the array is deliberately left out of reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = (LATENCY == 0) ? RESP : WAIT;
         WAIT:    if (wait_cnt == 4'd0) state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt   <= 4'd0;
         lat_write  <= 1'b0;
         lat_funct3 <= 3'd0;
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
         rsp_rdata  <= 32'd0;
         rsp_error  <= 1'b0;
      end else begin
         if (accept) begin
            lat_write  <= req_write;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            wait_cnt   <= CNT_INIT;
         end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         if (access_en) begin
            rsp_rdata <= (a_write || access_err) ? 32'd0 : load_data;
            rsp_error <= access_err;
         end else if (state == RESP && rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver queues hand-computed responses,
// a negedge monitor compares every presented response and its latency.
module tb_data_mem_responder;

   localparam int          DEPTH = 1024;
   localparam int          LAT   = 2;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   data_mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_error  (rsp_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   stamp_q[$];
   int   hs_cyc = -1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %08h, expected %08h", name, got, want);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input string name, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr,
                        input bit track, output int stamp);
      int   n = 0;
      exp_t e;
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      if (track) begin
         e.name  = name;
         e.rdata = erd;
         e.err   = eerr;
         exp_q.push_back(e);
      end
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      stamp = cyc;
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL %s accept: req_ready stayed 0 for %0d cycles, expected 1", name, n);
      end else if (track) begin
         stamp_q.push_back(cyc);
      end
      @(negedge clk);
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
   endtask

   task automatic ld(input string name, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] erd, input logic eerr);
      int s;
      issue(name, 1'b0, f3, a, 32'd0, erd, eerr, 1'b1, s);
   endtask

   task automatic st(input string name, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic eerr);
      int s;
      issue(name, 1'b1, f3, a, wd, 32'd0, eerr, 1'b1, s);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
      end
   endtask

   // Monitor: latency on each rising rsp_valid, payload on every presented cycle.
   initial begin
      bit   prev_valid = 1'b0;
      exp_t e;
      int   s;
      forever begin
         @(negedge clk);
         #1;
         if (rsp_valid && !prev_valid) begin
            if (stamp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL stray response: rsp_valid=1 with no accepted request");
            end else begin
               s = stamp_q.pop_front();
               check("rsp latency", 32'(cyc - s), 32'(LAT + 1));
            end
         end
         if (rsp_valid) begin
            check("req_ready during resp", {31'd0, req_ready}, 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected response: rdata %08h error %0b", rsp_rdata, rsp_error);
            end else begin
               e = exp_q[0];
               check({e.name, " rdata"}, rsp_rdata, e.rdata);
               check({e.name, " error"}, {31'd0, rsp_error}, {31'd0, e.err});
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  hs_cyc = cyc;
               end
            end
         end
         prev_valid = rsp_valid;
      end
   end

   initial begin
      #200000;
      checks++;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int s1, s2, n;
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      rsp_ready  = 1'b1;
      #1;
      check("reset req_ready", {31'd0, req_ready}, 32'd1);
      check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset rsp_rdata", rsp_rdata, 32'd0);
      check("reset rsp_error", {31'd0, rsp_error}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Word store and load-back
      st("sw 10", 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0);
      ld("lw 10", 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0);

      // Sub-word stores and extension
      st("sb 13",  3'd0, 32'h13, 32'h0000_0080, 1'b0);
      ld("lb 13",  3'd0, 32'h13, 32'hFFFF_FF80, 1'b0);
      ld("lbu 13", 3'd4, 32'h13, 32'h0000_0080, 1'b0);
      ld("lw 10b", 3'd2, 32'h10, 32'h80AD_BEEF, 1'b0);
      st("sh 10",  3'd1, 32'h10, 32'h0000_1234, 1'b0);
      ld("lhu 10", 3'd5, 32'h10, 32'h0000_1234, 1'b0);
      ld("lh 12",  3'd1, 32'h12, 32'hFFFF_80AD, 1'b0);
      ld("lhu 12", 3'd5, 32'h12, 32'h0000_80AD, 1'b0);

      // Faults
      ld("lh 11 misaligned", 3'd1, 32'h11, 32'd0, 1'b1);
      st("sw 12 misaligned", 3'd2, 32'h12, 32'h1111_1111, 1'b1);
      ld("lw 10 unchanged",  3'd2, 32'h10, 32'h80AD_1234, 1'b0);
      ld("load f3=3",        3'd3, 32'h10, 32'd0, 1'b1);
      ld("load f3=6",        3'd6, 32'h10, 32'd0, 1'b1);
      st("store f3=3",       3'd3, 32'h10, 32'hFFFF_FFFF, 1'b1);
      ld("lw 10 after bad st", 3'd2, 32'h10, 32'h80AD_1234, 1'b0);

      // Back-pressure: response held 5 cycles while a second request waits
      drain();
      rsp_ready = 1'b0;
      ld("hold lw 10", 3'd2, 32'h10, 32'h80AD_1234, 1'b0);
      fork
         issue("lbu after hold", 1'b0, 3'd4, 32'h10, 32'd0, 32'h0000_0034, 1'b0, 1'b1, s2);
         begin
            n = 0;
            while (!rsp_valid && n < 50) begin
               @(negedge clk);
               n++;
            end
            repeat (5) @(negedge clk);
            rsp_ready = 1'b1;
         end
      join
      check("accept one cycle after handshake", 32'(s2), 32'(hs_cyc + 1));

      // Range boundary
      ld("lw past end", 3'd2, BASE + 32'(4 * DEPTH), 32'd0, 1'b1);
      st("sw last",     3'd2, BASE + 32'(4 * (DEPTH - 1)), 32'h5A5A_A5A5, 1'b0);
      ld("lw last",     3'd2, BASE + 32'(4 * (DEPTH - 1)), 32'h5A5A_A5A5, 1'b0);

      // Reset in WAIT discards a pending store
      st("sw 20 init", 3'd2, 32'h20, 32'h0101_0101, 1'b0);
      issue("sw 20 dropped", 1'b1, 3'd2, 32'h20, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0, s1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid-wait reset req_ready", {31'd0, req_ready}, 32'd1);
      check("mid-wait reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("mid-wait reset rsp_rdata", rsp_rdata, 32'd0);
      check("mid-wait reset rsp_error", {31'd0, rsp_error}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      ld("lw 20 after reset", 3'd2, 32'h20, 32'h0101_0101, 1'b0);

      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
